// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine scheduler.
package gcd_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int unsigned DEF_W      = 8;
    localparam int unsigned DEF_NREQ   = 4;
    localparam int unsigned DEF_TO_CYC = 64;

    // Timer counts 0..to_cyc-1 in WAIT
    function automatic int unsigned timer_width(input int unsigned to_cyc);
        return $clog2(to_cyc);
    endfunction

endpackage

// File: rtl/gcd_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!valid && req[IW'(idx)]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin scheduler sharing one GCD engine among NREQ requesters,
// with a WAIT timeout and edge-detected engine DONE.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned W      = DEF_W,
    parameter int unsigned TO_CYC = DEF_TO_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_vld,
    output logic [W-1:0]      rsp_y,
    output logic              rsp_err,
    output logic              rsp_to,
    output logic              busy,
    output logic              gcd_start,
    output logic [W-1:0]      gcd_a,
    output logic [W-1:0]      gcd_b,
    input  logic              gcd_done,
    input  logic [W-1:0]      gcd_y,
    input  logic              gcd_error
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = timer_width(TO_CYC);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, owner, owner_n, arb_idx;
    logic [TW-1:0]   timer, timer_n;
    logic            done_d, done_ev, arb_vld;
    logic [NREQ-1:0] gnt_n, rsp_vld_n;
    logic            start_n, err_n, to_n;
    logic [W-1:0]    a_n, b_n, y_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (arb_idx),
        .valid  (arb_vld)
    );

    // Next-state and next-output decode
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        timer_n   = timer;
        gnt_n     = '0;
        rsp_vld_n = '0;
        start_n   = 1'b0;
        a_n       = gcd_a;
        b_n       = gcd_b;
        y_n       = rsp_y;
        err_n     = rsp_err;
        to_n      = rsp_to;
        done_ev   = gcd_done & ~done_d;

        unique case (state)
            IDLE: begin
                if (arb_vld) begin
                    owner_n = arb_idx;
                    a_n     = req_a[32'(arb_idx)*W +: W];
                    b_n     = req_b[32'(arb_idx)*W +: W];
                    gnt_n   = NREQ'(1) << arb_idx;
                    start_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A DONE edge wins over a simultaneous timeout
                if (done_ev) begin
                    y_n       = gcd_y;
                    err_n     = gcd_error;
                    to_n      = 1'b0;
                    rsp_vld_n = NREQ'(1) << owner;
                    state_n   = RESP;
                end else if (timer == TW'(TO_CYC - 1)) begin
                    y_n       = '0;
                    err_n     = 1'b1;
                    to_n      = 1'b1;
                    rsp_vld_n = NREQ'(1) << owner;
                    state_n   = RESP;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            RESP: begin
                ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            timer     <= '0;
            done_d    <= 1'b0;
            gnt       <= '0;
            rsp_vld   <= '0;
            rsp_y     <= '0;
            rsp_err   <= 1'b0;
            rsp_to    <= 1'b0;
            busy      <= 1'b0;
            gcd_start <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            timer     <= timer_n;
            done_d    <= gcd_done;
            gnt       <= gnt_n;
            rsp_vld   <= rsp_vld_n;
            rsp_y     <= y_n;
            rsp_err   <= err_n;
            rsp_to    <= to_n;
            busy      <= (state_n != IDLE);
            gcd_start <= start_n;
            gcd_a     <= a_n;
            gcd_b     <= b_n;
        end
    end

endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Round-robin scheduler that shares one GCD engine (START/A/B in; DONE/Y/ERROR out) between NREQ requesters. It accepts one request at a time and latches its operands. It pulses the engine's START, waits for DONE or a timeout, then returns the result to the owning requester. It sits between the client blocks and the single GCD engine instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width; must match the engine
TO_CYC, 64, max cycles in WAIT before timeout (>=2)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ  in  NREQ  per-requester request level; held with operands until GNT
REQ_A  in  NREQ*W  operand A, requester i in bits [i*W +: W]
REQ_B  in  NREQ*W  operand B, same packing
GNT  out  NREQ  one-hot, 1-cycle pulse: request accepted, operands latched
RSP_VLD  out  NREQ  one-hot, 1-cycle pulse: RSP_* valid for that requester
RSP_Y  out  W  result, held until next response
RSP_ERR  out  1  engine ERROR, or 1 on timeout; held
RSP_TO  out  1  timeout flag; held
BUSY  out  1  high in every state except IDLE
GCD_START  out  1  1-cycle start pulse to engine
GCD_A  out  W  latched operand A to engine
GCD_B  out  W  latched operand B to engine
GCD_DONE  in  1  engine done
GCD_Y  in  W  engine result, valid while GCD_DONE=1
GCD_ERROR  in  1  engine error, valid while GCD_DONE=1

Behaviour:
- Reset (async, RST_N=0): state=IDLE, PTR=0, owner=0, timer=0, done_d=0. All outputs 0, including RSP_Y/ERR/TO. Reset mid-operation aborts the job with no response. The engine is reset by the same RST_N.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or Moore-decoded; nothing passes combinationally from inputs to outputs.
- IDLE: if |REQ, select the first set bit searching PTR, PTR+1, ... modulo NREQ. Latch owner, REQ_A[owner] and REQ_B[owner] into GCD_A/GCD_B, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): GNT[owner]=1 and GCD_START=1. Clear the timer and go to WAIT.
- WAIT: done_d samples GCD_DONE every cycle. A DONE event is (GCD_DONE & ~done_d) in WAIT only.
  - On a DONE event: capture RSP_Y=GCD_Y, RSP_ERR=GCD_ERROR, RSP_TO=0, then go to RESP.
  - Otherwise the timer increments. When timer==TO_CYC-1: RSP_Y=0, RSP_ERR=1, RSP_TO=1, then go to RESP.
  - If a DONE event and the timeout occur in the same cycle, DONE wins.
- RESP (exactly 1 cycle): RSP_VLD[owner]=1, PTR=(owner+1) mod NREQ, then go to IDLE.
- GCD_A/GCD_B hold stable from ISSUE until the next IDLE acceptance.
- Engine contract: DONE drops no later than 1 cycle after START is sampled. A stale DONE left high from a previous job therefore creates no event.
- Latency: REQ seen in IDLE at edge k gives GNT/START in cycle k+1. RSP_VLD follows 1 cycle after the DONE edge is detected. Minimum back-to-back period is 4 cycles plus engine time.
- REQ changes outside IDLE are ignored. A request withdrawn before GNT is not served. The owner may re-request immediately; it is re-granted only after the other pending requesters (fairness).
- Operand width: no arithmetic is applied to operands; values pass through unmodified.

Decomposition:
- gcd_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, default W=8, NREQ=4, TO_CYC=64, and timer width $clog2(TO_CYC).
- Sub-module rr_arbiter (combinational): inputs REQ[NREQ] and PTR; outputs the winner index and a valid flag. It is instantiated once in gcd_arbiter.

Test Plan:
- Single request: REQ[0]=1, A=21, B=6 → one GNT[0] pulse and one GCD_START pulse with GCD_A=21, GCD_B=6; then RSP_VLD[0] with RSP_Y=3, RSP_ERR=0, RSP_TO=0, and BUSY low afterwards.
- Round robin: REQ=4'b1111 held, operands (21,21), (6,21), (233,144), (0,6) → grants in order 0,1,2,3 and again 0 while held. Responses: RSP_Y=21, 3, 1 on requesters 0–2; requester 3 sees RSP_ERR equal to the engine's GCD_ERROR for (0,6).
- Fairness: REQ[1] and REQ[3] held with PTR=2 → GNT[3] first, then GNT[1].
- Timeout: stub engine that never raises DONE, TO_CYC=64 → RSP_VLD[owner] exactly 64 cycles after entering WAIT, with RSP_ERR=1, RSP_TO=1, RSP_Y=0.
- Stale DONE: stub holds DONE=1 into the ISSUE cycle and drops it the next cycle, then pulses DONE with Y=7 → exactly one response, RSP_Y=7.
- Reset in WAIT: RST_N=0 mid-job → all outputs 0 immediately and no RSP_VLD. After release with REQ[2]=1 → GNT[2] and PTR restarts from 0.
